// File: rtl/i2c_target_responder_pkg.sv
// Shared I2C definitions: address width, ACK/NACK bus levels and target FSM states.
package i2c_target_responder_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam logic        I2C_ACK    = 1'b0;
    localparam logic        I2C_NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDRESS,
        ST_ADDR_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WRITE_DATA,
        ST_DATA_ACK,
        ST_READ_DATA,
        ST_MASTER_ACK,
        ST_WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_target_responder_if.sv
// Pad-side I2C lines plus the byte-wide register-file port of the target.
interface i2c_target_responder_if;

    logic       i2c_scl_in;
    logic       i2c_sda_in;
    logic       i2c_sda_control;
    logic [7:0] reg_address;
    logic [7:0] write_data;
    logic       write_strobe;
    logic [7:0] read_data;
    logic       read_strobe;
    logic       busy;

    modport slave (
        input  i2c_scl_in, i2c_sda_in, read_data,
        output i2c_sda_control, reg_address, write_data, write_strobe, read_strobe, busy
    );

    modport master (
        output i2c_scl_in, i2c_sda_in, read_data,
        input  i2c_sda_control, reg_address, write_data, write_strobe, read_strobe, busy
    );

endinterface

// File: rtl/i2c_target_responder_line_filter.sv
// One I2C line: 2-FF synchronizer, FILTER_DEPTH glitch filter, edge pulses.
module i2c_line_filter #(
    parameter int unsigned FILTER_DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] LAST_CNT = 4'(FILTER_DEPTH - 1);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       prev_q;
    logic [3:0] cnt_q, cnt_d;

    // Synchronizer, filtered level, its delayed copy and the run-length counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Adopt the synchronized level only after FILTER_DEPTH consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target endpoint: bus event decode, address match, register write/read port.
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDRESS = 7'h3C,
    parameter int unsigned           FILTER_DEPTH  = 3
) (
    input logic                   clock,
    input logic                   reset,
    i2c_target_responder_if.slave i2c
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk_i  (clock),
        .rst_ni (reset),
        .line_i (i2c.i2c_scl_in),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk_i  (clock),
        .rst_ni (reset),
        .line_i (i2c.i2c_sda_in),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       sda_ctrl_q, sda_ctrl_d;
    logic       wstrobe_q, wstrobe_d;
    logic       rstrobe_q, rstrobe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;

    logic       start_det, stop_det, rx_last;
    logic [7:0] rx_byte;

    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;
    assign rx_byte   = {shift_q[6:0], sda_lvl};
    assign rx_last   = scl_rise && (bit_cnt_q == 3'd7);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; START/STOP override bit handling. In ACK states sda_ctrl_q doubles
    // as the phase flag: still released means the first falling edge is pending.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDRESS;
        end else begin
            case (state_q)
                ST_ADDRESS: begin
                    if (rx_last) begin
                        state_d = (rx_byte[7:1] == SLAVE_ADDRESS) ? ST_ADDR_ACK : ST_WAIT_STOP;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && !sda_ctrl_q) begin
                        state_d = rw_q ? ST_READ_DATA : ST_REG_ADDR;
                    end
                end
                ST_REG_ADDR: if (rx_last) state_d = ST_REG_ACK;
                ST_REG_ACK, ST_DATA_ACK: begin
                    if (scl_fall && !sda_ctrl_q) state_d = ST_WRITE_DATA;
                end
                ST_WRITE_DATA: if (rx_last) state_d = ST_DATA_ACK;
                ST_READ_DATA: begin
                    if (scl_fall && (bit_cnt_q == 3'd7)) state_d = ST_MASTER_ACK;
                end
                ST_MASTER_ACK: begin
                    // A NACK leaves on the rising edge, so any falling edge here follows an ACK.
                    if (scl_rise && (sda_lvl == I2C_NACK)) begin
                        state_d = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d = ST_READ_DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values driven by the current state and bus events.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        sda_ctrl_d = sda_ctrl_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        wstrobe_d  = 1'b0;
        rstrobe_d  = (state_d == ST_READ_DATA) && (state_q != ST_READ_DATA);

        if (wstrobe_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end
        if (rstrobe_q) begin
            shift_d    = i2c.read_data;
            sda_ctrl_d = i2c.read_data[7];
        end

        if (stop_det) begin
            sda_ctrl_d = 1'b1;
            busy_d     = 1'b0;
        end else if (start_det) begin
            bit_cnt_d  = '0;
            sda_ctrl_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDRESS, ST_REG_ADDR, ST_WRITE_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (rx_last) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDRESS && rx_byte[7:1] == SLAVE_ADDRESS) begin
                            busy_d = 1'b1;
                            rw_d   = rx_byte[0];
                        end
                        if (state_q == ST_REG_ADDR) reg_addr_d = rx_byte;
                        if (state_q == ST_WRITE_DATA) begin
                            wdata_d   = rx_byte;
                            wstrobe_d = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                    if (scl_fall) sda_ctrl_d = sda_ctrl_q ? I2C_ACK : 1'b1;
                end
                ST_READ_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d  = '0;
                            sda_ctrl_d = 1'b1;
                        end else begin
                            shift_d    = {shift_q[6:0], 1'b0};
                            sda_ctrl_d = shift_q[6];
                        end
                    end
                end
                ST_MASTER_ACK: begin
                    if (scl_rise && (sda_lvl == I2C_ACK)) reg_addr_d = reg_addr_q + 8'd1;
                end
                default: sda_ctrl_d = 1'b1;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            sda_ctrl_q <= 1'b1;
            wstrobe_q  <= 1'b0;
            rstrobe_q  <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            sda_ctrl_q <= sda_ctrl_d;
            wstrobe_q  <= wstrobe_d;
            rstrobe_q  <= rstrobe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    assign i2c.i2c_sda_control = sda_ctrl_q;
    assign i2c.reg_address     = reg_addr_q;
    assign i2c.write_data      = wdata_q;
    assign i2c.write_strobe    = wstrobe_q;
    assign i2c.read_strobe     = rstrobe_q;
    assign i2c.busy            = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: bus-level initiator model with wired-AND SDA.
module tb_i2c_target_responder;

    logic clock = 1'b0;
    logic reset;
    logic scl_m, sda_m;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0, rd_cnt = 0, sda_low_cnt = 0;
    logic [7:0] wr_log_a [0:63];
    logic [7:0] wr_log_d [0:63];
    logic [7:0] rd_log_a [0:63];

    i2c_target_responder_if bus();

    assign bus.i2c_scl_in = scl_m;
    assign bus.i2c_sda_in = sda_m & bus.i2c_sda_control;
    assign bus.read_data  = (bus.reg_address == 8'h20) ? 8'h5A :
                            (bus.reg_address == 8'h21) ? 8'hC3 : 8'h00;

    i2c_target_responder #(
        .SLAVE_ADDRESS(7'h3C),
        .FILTER_DEPTH (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i2c  (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.write_strobe) begin
            wr_log_a[wr_cnt % 64] = bus.reg_address;
            wr_log_d[wr_cnt % 64] = bus.write_data;
            wr_cnt++;
        end
        if (bus.read_strobe) begin
            rd_log_a[rd_cnt % 64] = bus.reg_address;
            rd_cnt++;
        end
        if (!bus.i2c_sda_control) sda_low_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One SCL period starting and ending with SCL low; seen is the bus SDA mid-high.
    task automatic send_bit(input logic b, input logic glitch, output logic seen);
        tick(3); sda_m = b;
        tick(7); scl_m = 1'b1;
        tick(3);
        if (glitch) begin
            sda_m = ~b; tick(2); sda_m = b;
        end else begin
            tick(2);
        end
        seen = bus.i2c_sda_in;
        tick(5); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic seen;
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 7), seen);
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, seen);
            d[i] = seen;
        end
        send_bit(mack, 1'b0, seen);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(10); scl_m = 1'b0;
    endtask

    task automatic i2c_rep_start();
        tick(3); sda_m = 1'b1; tick(7); scl_m = 1'b1;
        tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(3); sda_m = 1'b0; tick(7); scl_m = 1'b1;
        tick(10); sda_m = 1'b1; tick(20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack, ok, seen;
        logic [7:0] d, dbyte;
        int         bw, br, bl;

        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        tick(5);
        check_eq("rst_sda", bus.i2c_sda_control, 1'b1);
        check_eq("rst_reg", bus.reg_address, 8'h00);
        check_eq("rst_wdata", bus.write_data, 8'h00);
        check_eq("rst_wstb", bus.write_strobe, 1'b0);
        check_eq("rst_rstb", bus.read_strobe, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        tick(10);

        // Single write 0x3C/W, reg 0x10, data 0xA5
        bw = wr_cnt;
        i2c_start();
        send_byte(8'h78, 1'b0, ack); check_eq("w_addr_ack", ack, 1'b0);
        check_eq("w_busy", bus.busy, 1'b1);
        send_byte(8'h10, 1'b0, ack); check_eq("w_reg_ack", ack, 1'b0);
        send_byte(8'hA5, 1'b0, ack); check_eq("w_data_ack", ack, 1'b0);
        i2c_stop();
        check_eq("w_busy_end", bus.busy, 1'b0);
        check_eq("w_count", wr_cnt - bw, 1);
        check_eq("w_addr", wr_log_a[bw % 64], 8'h10);
        check_eq("w_data", wr_log_d[bw % 64], 8'hA5);
        check_eq("w_wdata_out", bus.write_data, 8'hA5);
        check_eq("w_reg_inc", bus.reg_address, 8'h11);

        // Foreign address 0x3D/W
        bw = wr_cnt; br = rd_cnt; bl = sda_low_cnt;
        i2c_start();
        send_byte(8'h7A, 1'b0, ack); check_eq("nm_addr_nack", ack, 1'b1);
        send_byte(8'h10, 1'b0, ack); check_eq("nm_byte_nack", ack, 1'b1);
        i2c_stop();
        check_eq("nm_sda_low", sda_low_cnt - bl, 0);
        check_eq("nm_wstb", wr_cnt - bw, 0);
        check_eq("nm_rstb", rd_cnt - br, 0);
        check_eq("nm_busy", bus.busy, 1'b0);

        // Register pointer write, repeated START, two reads
        bw = wr_cnt; br = rd_cnt;
        i2c_start();
        send_byte(8'h78, 1'b0, ack); check_eq("r_addr_ack", ack, 1'b0);
        send_byte(8'h20, 1'b0, ack); check_eq("r_reg_ack", ack, 1'b0);
        i2c_rep_start();
        send_byte(8'h79, 1'b0, ack); check_eq("r_raddr_ack", ack, 1'b0);
        recv_byte(1'b0, d); check_eq("r_byte0", d, 8'h5A);
        recv_byte(1'b1, d); check_eq("r_byte1", d, 8'hC3);
        tick(20);
        check_eq("r_wait_sda", bus.i2c_sda_control, 1'b1);
        check_eq("r_wait_busy", bus.busy, 1'b1);
        check_eq("r_rstb_count", rd_cnt - br, 2);
        check_eq("r_rstb0_addr", rd_log_a[br % 64], 8'h20);
        check_eq("r_rstb1_addr", rd_log_a[(br + 1) % 64], 8'h21);
        check_eq("r_no_wstb", wr_cnt - bw, 0);
        i2c_stop();
        check_eq("r_busy_end", bus.busy, 1'b0);
        check_eq("r_reg_final", bus.reg_address, 8'h21);

        // Burst write wrapping the register pointer
        bw = wr_cnt;
        i2c_start();
        send_byte(8'h78, 1'b0, ack); check_eq("b_addr_ack", ack, 1'b0);
        send_byte(8'hFE, 1'b0, ack); check_eq("b_reg_ack", ack, 1'b0);
        send_byte(8'h01, 1'b0, ack); check_eq("b_d0_ack", ack, 1'b0);
        send_byte(8'h02, 1'b0, ack); check_eq("b_d1_ack", ack, 1'b0);
        send_byte(8'h03, 1'b0, ack); check_eq("b_d2_ack", ack, 1'b0);
        i2c_stop();
        check_eq("b_count", wr_cnt - bw, 3);
        check_eq("b_a0", wr_log_a[bw % 64], 8'hFE);
        check_eq("b_d0", wr_log_d[bw % 64], 8'h01);
        check_eq("b_a1", wr_log_a[(bw + 1) % 64], 8'hFF);
        check_eq("b_d1", wr_log_d[(bw + 1) % 64], 8'h02);
        check_eq("b_a2", wr_log_a[(bw + 2) % 64], 8'h00);
        check_eq("b_d2", wr_log_d[(bw + 2) % 64], 8'h03);
        check_eq("b_reg_final", bus.reg_address, 8'h01);

        // 2-cycle SDA low glitch on an idle bus must not look like START
        bl = sda_low_cnt;
        sda_m = 1'b0; tick(2); sda_m = 1'b1;
        tick(20);
        scl_m = 1'b0;
        send_byte(8'h78, 1'b0, ack); check_eq("g_start_nack", ack, 1'b1);
        i2c_stop();
        check_eq("g_start_busy", bus.busy, 1'b0);
        check_eq("g_start_sda", sda_low_cnt - bl, 0);

        // 2-cycle SDA high glitch during a high SCL data bit must not look like STOP
        bw = wr_cnt;
        i2c_start();
        send_byte(8'h78, 1'b0, ack); check_eq("g_addr_ack", ack, 1'b0);
        send_byte(8'h30, 1'b0, ack); check_eq("g_reg_ack", ack, 1'b0);
        send_byte(8'h00, 1'b1, ack); check_eq("g_data_ack", ack, 1'b0);
        check_eq("g_busy", bus.busy, 1'b1);
        i2c_stop();
        check_eq("g_count", wr_cnt - bw, 1);
        check_eq("g_a", wr_log_a[bw % 64], 8'h30);
        check_eq("g_d", wr_log_d[bw % 64], 8'h00);

        // Reset while the target drives the data ACK
        i2c_start();
        send_byte(8'h78, 1'b0, ack); check_eq("x_addr_ack", ack, 1'b0);
        send_byte(8'h40, 1'b0, ack); check_eq("x_reg_ack", ack, 1'b0);
        dbyte = 8'h77;
        for (int i = 7; i >= 0; i--) send_bit(dbyte[i], 1'b0, seen);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.i2c_sda_control == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check_eq("x_ack_driven", ok, 1'b1);
        check_eq("x_pre_reg", bus.reg_address, 8'h41);
        check_eq("x_pre_wdata", bus.write_data, 8'h77);
        reset = 1'b0;
        tick(1);
        check_eq("x_sda", bus.i2c_sda_control, 1'b1);
        check_eq("x_reg", bus.reg_address, 8'h00);
        check_eq("x_wdata", bus.write_data, 8'h00);
        check_eq("x_busy", bus.busy, 1'b0);
        check_eq("x_wstb", bus.write_strobe, 1'b0);
        check_eq("x_rstb", bus.read_strobe, 1'b0);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
